// File: rtl/display_annot_packetizer.sv
// Wraps bbox lists, camera frames and logo frames into typed packets
// (header, fixed-length payload, trailer) behind a single output register.
module display_annot_packetizer #(
  parameter int unsigned FRAME_WIDTH  = 540,
  parameter int unsigned FRAME_HEIGHT = 540,
  parameter int unsigned MAX_BBOX     = 16,
  parameter int unsigned LOGO_WIDTH   = 540,
  parameter int unsigned LOGO_HEIGHT  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bbox_valid,
  input  logic        bbox_last,
  input  logic [63:0] bbox_data,
  output logic        bbox_ready,
  input  logic        pix_valid,
  input  logic [63:0] pix_data,
  output logic        pix_ready,
  input  logic        logo_valid,
  input  logic [63:0] logo_data,
  output logic        logo_ready,
  output logic        out_valid,
  output logic        out_last,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic [15:0] frame_cnt
);

  localparam int unsigned IMG_COUNT  = FRAME_WIDTH * FRAME_HEIGHT / 2;
  localparam int unsigned LOGO_COUNT = LOGO_WIDTH * LOGO_HEIGHT / 2;

  localparam logic [21:0] IMG_LAST  = 22'(IMG_COUNT - 1);
  localparam logic [21:0] LOGO_LAST = 22'(LOGO_COUNT - 1);
  localparam logic [21:0] BBOX_LAST = 22'(MAX_BBOX - 1);

  localparam logic [23:0] IMG_WORDS  = 24'(IMG_COUNT);
  localparam logic [23:0] LOGO_WORDS = 24'(LOGO_COUNT);
  localparam logic [23:0] BBOX_WORDS = 24'(MAX_BBOX);

  localparam logic [2:0] TYPE_IMAGE = 3'd1;
  localparam logic [2:0] TYPE_BBOX  = 3'd2;
  localparam logic [2:0] TYPE_LOGO  = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    IMAGE,
    LOGO,
    BBOX,
    PAD,
    DROP,
    TRAIL
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [21:0] cnt;
  logic        pkt_image;
  logic        adv;

  logic        bbox_rdy;
  logic        pix_rdy;
  logic        logo_rdy;
  logic        load;
  logic        load_last;
  logic [63:0] load_data;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        hdr_image;
  logic        frame_inc;

  function automatic logic [63:0] header(input logic [2:0]  kind,
                                         input logic [23:0] count,
                                         input logic [15:0] frame);
    return {16'h0000, frame, count, 5'b00000, kind};
  endfunction

  assign adv = ~out_valid | out_ready;

  // Readies are forced low during reset so no source word is lost to an
  // abandoned packet.
  assign bbox_ready = bbox_rdy & ~rst;
  assign pix_ready  = pix_rdy & ~rst;
  assign logo_ready = logo_rdy & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (adv) begin
          if (bbox_valid) begin
            state_next = BBOX;
          end else if (pix_valid) begin
            state_next = IMAGE;
          end else if (logo_valid) begin
            state_next = LOGO;
          end
        end
      end
      IMAGE: begin
        if (pix_valid && adv && cnt == IMG_LAST) begin
          state_next = TRAIL;
        end
      end
      LOGO: begin
        if (logo_valid && adv && cnt == LOGO_LAST) begin
          state_next = TRAIL;
        end
      end
      BBOX: begin
        if (bbox_valid && adv) begin
          if (cnt == BBOX_LAST) begin
            state_next = bbox_last ? TRAIL : DROP;
          end else if (bbox_last) begin
            state_next = PAD;
          end
        end
      end
      PAD: begin
        if (adv && cnt == BBOX_LAST) begin
          state_next = TRAIL;
        end
      end
      DROP: begin
        if (bbox_valid && bbox_last) begin
          state_next = TRAIL;
        end
      end
      TRAIL: begin
        if (adv) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bbox_rdy  = 1'b0;
    pix_rdy   = 1'b0;
    logo_rdy  = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    load_data = '0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    hdr_image = 1'b0;
    frame_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (adv) begin
          if (bbox_valid) begin
            load      = 1'b1;
            cnt_clr   = 1'b1;
            load_data = header(TYPE_BBOX, BBOX_WORDS, frame_cnt);
          end else if (pix_valid) begin
            load      = 1'b1;
            cnt_clr   = 1'b1;
            hdr_image = 1'b1;
            load_data = header(TYPE_IMAGE, IMG_WORDS, frame_cnt);
          end else if (logo_valid) begin
            load      = 1'b1;
            cnt_clr   = 1'b1;
            load_data = header(TYPE_LOGO, LOGO_WORDS, frame_cnt);
          end
        end
      end
      IMAGE: begin
        pix_rdy = adv;
        if (pix_valid && adv) begin
          load      = 1'b1;
          cnt_inc   = 1'b1;
          load_data = pix_data;
        end
      end
      LOGO: begin
        logo_rdy = adv;
        if (logo_valid && adv) begin
          load      = 1'b1;
          cnt_inc   = 1'b1;
          load_data = logo_data;
        end
      end
      BBOX: begin
        bbox_rdy = adv;
        if (bbox_valid && adv) begin
          load      = 1'b1;
          cnt_inc   = 1'b1;
          load_data = bbox_data;
        end
      end
      PAD: begin
        if (adv) begin
          load    = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      DROP: begin
        // Surplus entries are swallowed unconditionally; the output path
        // simply drains meanwhile.
        bbox_rdy = 1'b1;
      end
      TRAIL: begin
        if (adv) begin
          load      = 1'b1;
          load_last = 1'b1;
          frame_inc = pkt_image;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      cnt       <= '0;
      pkt_image <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (adv) begin
        out_valid <= load;
        out_last  <= load & load_last;
        if (load) begin
          out_data <= load_data;
        end
      end
      if (cnt_clr) begin
        cnt       <= '0;
        pkt_image <= hdr_image;
      end else if (cnt_inc) begin
        cnt <= cnt + 22'd1;
      end
      if (frame_inc) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_display_annot_packetizer.sv
// Bench for display_annot_packetizer: queued source stimulus, an expected-word
// scoreboard checked at every output handshake, plus packet-level checks.
module tb_display_annot_packetizer;

  localparam int unsigned MAXB = 4;

  logic        clk;
  logic        rst;
  logic        bbox_valid;
  logic        bbox_last;
  logic [63:0] bbox_data;
  logic        bbox_ready;
  logic        pix_valid;
  logic [63:0] pix_data;
  logic        pix_ready;
  logic        logo_valid;
  logic [63:0] logo_data;
  logic        logo_ready;
  logic        out_valid;
  logic        out_last;
  logic [63:0] out_data;
  logic        out_ready;
  logic [15:0] frame_cnt;

  display_annot_packetizer #(
    .FRAME_WIDTH (4),
    .FRAME_HEIGHT(2),
    .MAX_BBOX    (MAXB),
    .LOGO_WIDTH  (4),
    .LOGO_HEIGHT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bbox_valid(bbox_valid),
    .bbox_last (bbox_last),
    .bbox_data (bbox_data),
    .bbox_ready(bbox_ready),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .logo_valid(logo_valid),
    .logo_data (logo_data),
    .logo_ready(logo_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } word_t;

  typedef struct {
    int          kind;
    int          n;
    logic [63:0] base;
    logic [63:0] hdr;
    int          len;
    logic [15:0] frame_after;
  } vec_t;

  word_t       bbox_q[$];
  word_t       exp_q[$];
  logic [63:0] pix_q[$];
  logic [63:0] logo_q[$];

  int    vectors = 0;
  int    miscompares = 0;
  bit    rand_ready = 1'b0;
  bit    pix_gaps = 1'b0;
  int    bbox_n = 0;
  int    pad_watch = 0;
  int    pkt_words = 0;
  int    last_len = 0;
  int    logo_acc = 0;
  bit    stalled = 1'b0;
  word_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic last, input logic [63:0] data);
    word_t w;
    w.last = last;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Model: bbox lists are truncated or zero-padded to MAXB payload words.
  task automatic queue_packet(input int kind, input int n, input logic [63:0] base,
                              input logic [63:0] hdr);
    word_t w;
    push_exp(1'b0, hdr);
    for (int i = 0; i < n; i++) begin
      case (kind)
        1: pix_q.push_back(base + 64'(i));
        3: logo_q.push_back(base + 64'(i));
        default: begin
          w.last = (i == n - 1);
          w.data = base + 64'(i);
          bbox_q.push_back(w);
        end
      endcase
      if (kind != 2) push_exp(1'b0, base + 64'(i));
    end
    if (kind == 2) begin
      for (int i = 0; i < int'(MAXB); i++) begin
        push_exp(1'b0, (i < n) ? base + 64'(i) : 64'h0);
      end
    end
    push_exp(1'b1, 64'h0);
  endtask

  task automatic cycle();
    word_t w;
    @(negedge clk);
    out_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    bbox_valid = (bbox_q.size() > 0);
    bbox_data  = bbox_valid ? bbox_q[0].data : 64'h0;
    bbox_last  = bbox_valid ? bbox_q[0].last : 1'b0;
    pix_valid  = (pix_q.size() > 0) && !(pix_gaps && $urandom_range(0, 2) == 0);
    pix_data   = pix_valid ? pix_q[0] : 64'h0;
    logo_valid = (logo_q.size() > 0);
    logo_data  = logo_valid ? logo_q[0] : 64'h0;
    #1;
    check("one_ready", 64'((int'(bbox_ready) + int'(pix_ready) + int'(logo_ready)) > 1), 64'h0);
    if (pad_watch > 0) begin
      check("bbox_ready_in_pad", 64'(bbox_ready), 64'h0);
      pad_watch--;
    end
    if (stalled) begin
      check("stall_valid", 64'(out_valid), 64'h1);
      check("stall_data", out_data, held.data);
      check("stall_last", 64'(out_last), 64'(held.last));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_word: got 0x%h last=%0b, expected no word", out_data, out_last);
      end else begin
        w = exp_q.pop_front();
        check("out_data", out_data, w.data);
        check("out_last", 64'(out_last), 64'(w.last));
      end
      if (out_last) begin
        last_len  = pkt_words + 1;
        pkt_words = 0;
      end else begin
        pkt_words++;
      end
    end
    stalled   = out_valid && !out_ready;
    held.data = out_data;
    held.last = out_last;
    if (bbox_valid && bbox_ready) begin
      w = bbox_q.pop_front();
      bbox_n++;
      if (w.last) begin
        if (bbox_n < int'(MAXB)) pad_watch = int'(MAXB) - bbox_n;
        bbox_n = 0;
      end
    end
    if (pix_valid && pix_ready) void'(pix_q.pop_front());
    if (logo_valid && logo_ready) begin
      void'(logo_q.pop_front());
      logo_acc++;
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 500;
    while ((bbox_q.size() + pix_q.size() + logo_q.size() + exp_q.size()) > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d words outstanding, expected 0", name, exp_q.size());
    end
    repeat (4) cycle();
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 4, 64'hA0,  64'h0000_0000_0000_0401, 6, 16'd1};
    vecs[1] = '{2, 2, 64'hB0,  64'h0000_0001_0000_0402, 6, 16'd1};
    vecs[2] = '{2, 6, 64'h100, 64'h0000_0001_0000_0402, 6, 16'd1};
    vecs[3] = '{3, 4, 64'hC0,  64'h0000_0001_0000_0403, 6, 16'd1};
    vecs[4] = '{2, 4, 64'hE0,  64'h0000_0001_0000_0402, 6, 16'd1};
    vecs[5] = '{2, 1, 64'hF0,  64'h0000_0001_0000_0402, 6, 16'd1};

    rst        = 1'b1;
    bbox_valid = 1'b0;
    bbox_last  = 1'b0;
    bbox_data  = '0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    logo_valid = 1'b0;
    logo_data  = '0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_last", 64'(out_last), 64'h0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_readies", 64'({bbox_ready, pix_ready, logo_ready}), 64'h0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'h0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      queue_packet(vecs[v].kind, vecs[v].n, vecs[v].base, vecs[v].hdr);
      drain("vec");
      check("pkt_len", 64'(last_len), 64'(vecs[v].len));
      check("frame_cnt", 64'(frame_cnt), 64'(vecs[v].frame_after));
    end

    // bbox and image valid together: the bbox packet must go out first.
    queue_packet(2, 3, 64'h300, 64'h0000_0001_0000_0402);
    queue_packet(1, 4, 64'h400, 64'h0000_0001_0000_0401);
    drain("priority");
    check("prio_frame_cnt", 64'(frame_cnt), 64'h2);

    rand_ready = 1'b1;
    pix_gaps   = 1'b1;
    queue_packet(1, 4, 64'hD0, 64'h0000_0002_0000_0401);
    drain("stall");
    check("stall_pkt_len", 64'(last_len), 64'h6);
    check("stall_frame_cnt", 64'(frame_cnt), 64'h3);
    rand_ready = 1'b0;
    pix_gaps   = 1'b0;

    // Reset while logo payload word 2 is on offer.
    logo_acc = 0;
    queue_packet(3, 4, 64'h500, 64'h0000_0003_0000_0403);
    begin
      int budget;
      budget = 100;
      while (logo_acc < 2 && budget > 0) begin
        cycle();
        budget--;
      end
      if (budget == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mid_logo_timeout: %0d logo words accepted, expected 2", logo_acc);
      end
    end
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'h0);
    check("mrst_readies", 64'({bbox_ready, pix_ready, logo_ready}), 64'h0);
    check("mrst_frame_cnt", 64'(frame_cnt), 64'h0);
    rst        = 1'b0;
    logo_valid = 1'b0;
    logo_data  = '0;
    #1;
    check("mrst_readies_idle", 64'({bbox_ready, pix_ready, logo_ready}), 64'h0);
    exp_q.delete();
    logo_q.delete();
    bbox_n    = 0;
    pad_watch = 0;
    pkt_words = 0;
    stalled   = 1'b0;
    queue_packet(3, 4, 64'h600, 64'h0000_0000_0000_0403);
    drain("post_rst");
    check("post_rst_pkt_len", 64'(last_len), 64'h6);
    check("post_rst_frame_cnt", 64'(frame_cnt), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
